// File: rtl/lsu_io_ctrl.sv
// Memory-mapped LED/HEX/LCD/switch/key register block behind the LSU address decoder.
// Loads are registered (1-cycle latency); keys are synchronised, debounced and edge-captured.
module lsu_io_ctrl #(
    parameter logic [31:0] BASE       = 32'h1000_0000,
    parameter int unsigned LEDR_W     = 17,
    parameter int unsigned LEDG_W     = 8,
    parameter int unsigned NUM_HEX    = 8,
    parameter int unsigned NUM_SW     = 18,
    parameter int unsigned NUM_KEY    = 4,
    parameter int unsigned DEB_CYCLES = 50000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [31:0]          i_lsu_addr,
    input  logic [31:0]          i_st_data,
    input  logic [3:0]           i_bmask,
    input  logic                 i_lsu_wren,
    input  logic                 i_lsu_rden,
    input  logic [NUM_SW-1:0]    i_io_sw,
    input  logic [NUM_KEY-1:0]   i_io_key,
    output logic [31:0]          o_ld_data,
    output logic                 o_ld_valid,
    output logic                 o_hit,
    output logic [LEDR_W-1:0]    o_io_ledr,
    output logic [LEDG_W-1:0]    o_io_ledg,
    output logic [7*NUM_HEX-1:0] o_io_hex,
    output logic [31:0]          o_io_lcd,
    output logic                 o_key_irq
);
    localparam int unsigned CntW = $clog2(DEB_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

    localparam logic [31:0] AdrLedr  = BASE + 32'h0_0000;
    localparam logic [31:0] AdrLedg  = BASE + 32'h0_1000;
    localparam logic [31:0] AdrHex03 = BASE + 32'h0_2000;
    localparam logic [31:0] AdrHex47 = BASE + 32'h0_3000;
    localparam logic [31:0] AdrLcd   = BASE + 32'h0_4000;
    localparam logic [31:0] AdrKey   = BASE + 32'h0_5000;
    localparam logic [31:0] AdrKedge = BASE + 32'h0_5004;
    localparam logic [31:0] AdrKmask = BASE + 32'h0_5008;
    localparam logic [31:0] AdrSw    = BASE + 32'h1_0000;

    logic sel_ledr, sel_ledg, sel_hex03, sel_hex47, sel_lcd;
    logic sel_key, sel_kedge, sel_kmask, sel_sw;
    logic unused_addr;

    assign sel_ledr    = (i_lsu_addr[31:2] == AdrLedr[31:2]);
    assign sel_ledg    = (i_lsu_addr[31:2] == AdrLedg[31:2]);
    assign sel_hex03   = (i_lsu_addr[31:2] == AdrHex03[31:2]);
    assign sel_hex47   = (NUM_HEX == 8) && (i_lsu_addr[31:2] == AdrHex47[31:2]);
    assign sel_lcd     = (i_lsu_addr[31:2] == AdrLcd[31:2]);
    assign sel_key     = (i_lsu_addr[31:2] == AdrKey[31:2]);
    assign sel_kedge   = (i_lsu_addr[31:2] == AdrKedge[31:2]);
    assign sel_kmask   = (i_lsu_addr[31:2] == AdrKmask[31:2]);
    assign sel_sw      = (i_lsu_addr[31:2] == AdrSw[31:2]);
    assign unused_addr = ^i_lsu_addr[1:0];

    assign o_hit = sel_ledr | sel_ledg | sel_hex03 | sel_hex47 | sel_lcd |
                   sel_key | sel_kedge | sel_kmask | sel_sw;

    logic [31:0]         bm32;
    logic [LEDR_W-1:0]   ledr_q, ledr_d;
    logic [LEDG_W-1:0]   ledg_q, ledg_d;
    logic [31:0]         lcd_q, lcd_d;
    logic [NUM_KEY-1:0]  mask_q, mask_d, edge_q, edge_d, clr, rise, key_stable;
    logic [NUM_KEY-1:0]  key_s1_q, key_s2_q;
    logic [NUM_SW-1:0]   sw_s1_q, sw_s2_q;
    logic [31:0]         hex03_rd, hex47_rd, rd_data;
    logic [31:0]         ld_data_q;
    logic                ld_valid_q, irq_q;

    assign bm32 = {{8{i_bmask[3]}}, {8{i_bmask[2]}}, {8{i_bmask[1]}}, {8{i_bmask[0]}}};
    assign clr  = (i_lsu_wren && sel_kedge) ? (i_st_data[NUM_KEY-1:0] & bm32[NUM_KEY-1:0]) : '0;

    always_comb begin
        ledr_d = ledr_q;
        ledg_d = ledg_q;
        lcd_d  = lcd_q;
        mask_d = mask_q;
        // A new press edge beats a simultaneous W1C clear.
        edge_d = (edge_q & ~clr) | rise;
        if (i_lsu_wren) begin
            if (sel_ledr) begin
                ledr_d = (ledr_q & ~bm32[LEDR_W-1:0]) | (i_st_data[LEDR_W-1:0] & bm32[LEDR_W-1:0]);
            end
            if (sel_ledg) begin
                ledg_d = (ledg_q & ~bm32[LEDG_W-1:0]) | (i_st_data[LEDG_W-1:0] & bm32[LEDG_W-1:0]);
            end
            if (sel_lcd) begin
                lcd_d = (lcd_q & ~bm32) | (i_st_data & bm32);
            end
            if (sel_kmask) begin
                mask_d = (mask_q & ~bm32[NUM_KEY-1:0]) | (i_st_data[NUM_KEY-1:0] & bm32[NUM_KEY-1:0]);
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (sel_ledr)       rd_data = 32'(ledr_q);
        else if (sel_ledg)  rd_data = 32'(ledg_q);
        else if (sel_hex03) rd_data = hex03_rd;
        else if (sel_hex47) rd_data = hex47_rd;
        else if (sel_lcd)   rd_data = lcd_q;
        else if (sel_key)   rd_data = 32'(key_stable);
        else if (sel_kedge) rd_data = 32'(edge_q);
        else if (sel_kmask) rd_data = 32'(mask_q);
        else if (sel_sw)    rd_data = 32'(sw_s2_q);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ledr_q     <= '0;
            ledg_q     <= '0;
            lcd_q      <= '0;
            mask_q     <= '0;
            edge_q     <= '0;
            key_s1_q   <= '0;
            key_s2_q   <= '0;
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
            ld_data_q  <= '0;
            ld_valid_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ledr_q     <= ledr_d;
            ledg_q     <= ledg_d;
            lcd_q      <= lcd_d;
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            // Keys are inverted ahead of the synchroniser so a cleared flop means released.
            key_s1_q   <= ~i_io_key;
            key_s2_q   <= key_s1_q;
            sw_s1_q    <= i_io_sw;
            sw_s2_q    <= sw_s1_q;
            ld_valid_q <= i_lsu_rden;
            irq_q      <= |(edge_q & mask_q);
            if (i_lsu_rden) ld_data_q <= rd_data;
        end
    end

    for (genvar k = 0; k < NUM_KEY; k++) begin : g_key
        logic [CntW-1:0] cnt_q, cnt_d;
        logic            stable_q, stable_d;

        always_comb begin
            cnt_d    = cnt_q;
            stable_d = stable_q;
            if (key_s2_q[k] == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == CntMax) begin
                cnt_d    = '0;
                stable_d = key_s2_q[k];
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end

        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                cnt_q    <= '0;
                stable_q <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                stable_q <= stable_d;
            end
        end

        assign key_stable[k] = stable_q;
        assign rise[k]       = ~stable_q & stable_d;
    end

    for (genvar d = 0; d < NUM_HEX; d++) begin : g_hex
        localparam int unsigned Lane = d % 4;
        logic       sel;
        logic [6:0] dig_q;

        assign sel = (d < 4) ? sel_hex03 : sel_hex47;

        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                dig_q <= '0;
            end else if (i_lsu_wren && sel && i_bmask[Lane]) begin
                dig_q <= i_st_data[8*Lane +: 7];
            end
        end

        assign o_io_hex[7*d +: 7] = dig_q;
        if (d < 4) begin : g_lo
            assign hex03_rd[8*d +: 8] = {1'b0, dig_q};
        end else begin : g_hi
            assign hex47_rd[8*(d-4) +: 8] = {1'b0, dig_q};
        end
    end

    if (NUM_HEX < 8) begin : g_no47
        assign hex47_rd = '0;
    end

    assign o_ld_data  = ld_data_q;
    assign o_ld_valid = ld_valid_q;
    assign o_io_ledr  = ledr_q;
    assign o_io_ledg  = ledg_q;
    assign o_io_lcd   = lcd_q;
    assign o_key_irq  = irq_q;
endmodule

// File: tb/tb_lsu_io_ctrl.sv
// Bench for lsu_io_ctrl: directed scenarios plus random bus/key traffic, all compared against a
// cycle-level register-map model held in the bench.
module tb_lsu_io_ctrl;
    localparam logic [31:0] Base = 32'h1000_0000;
    localparam int Deb = 4;

    logic        clk, rst;
    logic [31:0] addr, st_data;
    logic [3:0]  bmask, key;
    logic        wren, rden;
    logic [17:0] sw;

    logic [31:0] ld_data, lcd;
    logic        ld_valid, hit, irq;
    logic [16:0] ledr;
    logic [7:0]  ledg;
    logic [55:0] hex;

    logic [31:0] ld_data4, unused_lcd4;
    logic        ld_valid4, hit4, unused_irq4;
    logic [16:0] unused_ledr4;
    logic [7:0]  unused_ledg4;
    logic [27:0] hex4;

    lsu_io_ctrl #(.BASE(Base), .NUM_HEX(8), .DEB_CYCLES(Deb)) u_dut (
        .i_clk(clk), .i_reset(rst), .i_lsu_addr(addr), .i_st_data(st_data), .i_bmask(bmask),
        .i_lsu_wren(wren), .i_lsu_rden(rden), .i_io_sw(sw), .i_io_key(key),
        .o_ld_data(ld_data), .o_ld_valid(ld_valid), .o_hit(hit), .o_io_ledr(ledr),
        .o_io_ledg(ledg), .o_io_hex(hex), .o_io_lcd(lcd), .o_key_irq(irq)
    );

    lsu_io_ctrl #(.BASE(Base), .NUM_HEX(4), .DEB_CYCLES(Deb)) u_dut4 (
        .i_clk(clk), .i_reset(rst), .i_lsu_addr(addr), .i_st_data(st_data), .i_bmask(bmask),
        .i_lsu_wren(wren), .i_lsu_rden(rden), .i_io_sw(sw), .i_io_key(key),
        .o_ld_data(ld_data4), .o_ld_valid(ld_valid4), .o_hit(hit4), .o_io_ledr(unused_ledr4),
        .o_io_ledg(unused_ledg4), .o_io_hex(hex4), .o_io_lcd(unused_lcd4),
        .o_key_irq(unused_irq4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: architectural register contents plus key/switch history.
    logic [31:0] m_ledr, m_ledg, m_lcd, m_ld_data;
    logic [6:0]  m_hex [8];
    logic [3:0]  m_mask, m_edge, m_stable;
    logic [3:0]  m_khist [2];
    logic [17:0] m_swhist [2];
    int          m_run [4];
    logic        m_irq, m_ld_valid;

    task automatic model_reset();
        m_ledr = 0; m_ledg = 0; m_lcd = 0; m_ld_data = 0;
        m_mask = 0; m_edge = 0; m_stable = 0; m_irq = 0; m_ld_valid = 0;
        for (int i = 0; i < 8; i++) m_hex[i] = 0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        m_khist[0] = 0; m_khist[1] = 0; m_swhist[0] = 0; m_swhist[1] = 0;
    endtask

    function automatic logic [31:0] offset_of(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return w - Base;
    endfunction

    function automatic logic is_mapped(input logic [31:0] a, input int nhex);
        case (offset_of(a))
            32'h0, 32'h1000, 32'h2000, 32'h4000, 32'h5000, 32'h5004, 32'h5008, 32'h1_0000:
                return 1'b1;
            32'h3000: return nhex == 8;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] bm);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (bm[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] r;
        r = 0;
        case (offset_of(a))
            32'h0:    r = m_ledr;
            32'h1000: r = m_ledg;
            32'h2000: for (int d = 0; d < 4; d++) r[8*d +: 7] = m_hex[d];
            32'h3000: for (int d = 0; d < 4; d++) r[8*d +: 7] = m_hex[4+d];
            32'h4000: r = m_lcd;
            32'h5000: r = {28'h0, m_stable};
            32'h5004: r = {28'h0, m_edge};
            32'h5008: r = {28'h0, m_mask};
            32'h1_0000: r = {14'h0, m_swhist[1]};
            default:  r = 0;
        endcase
        return r;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] bm);
        logic [31:0] t;
        case (offset_of(a))
            32'h0:    m_ledr = merge(m_ledr, d, bm) & 32'h1_FFFF;
            32'h1000: m_ledg = merge(m_ledg, d, bm) & 32'hFF;
            32'h2000: for (int k = 0; k < 4; k++) if (bm[k]) m_hex[k] = d[8*k +: 7];
            32'h3000: for (int k = 0; k < 4; k++) if (bm[k]) m_hex[4+k] = d[8*k +: 7];
            32'h4000: m_lcd = merge(m_lcd, d, bm);
            32'h5004: if (bm[0]) m_edge = m_edge & ~d[3:0];
            32'h5008: begin
                t = merge({28'h0, m_mask}, d, bm);
                m_mask = t[3:0];
            end
            default: ;
        endcase
    endtask

    // One clock: advance the model with the inputs the DUT sees at this edge, then compare.
    task automatic tick();
        logic [31:0] ld;
        logic [3:0]  rise;
        logic        irq_n;
        logic [55:0] exp_hex;
        #1;
        check("hit", hit, is_mapped(addr, 8));
        ld = model_read(addr);
        irq_n = |(m_edge & m_mask);
        rise = 0;
        for (int i = 0; i < 4; i++) begin
            if (m_khist[1][i] != m_stable[i]) begin
                m_run[i]++;
                if (m_run[i] == Deb) begin
                    m_stable[i] = m_khist[1][i];
                    rise[i] = m_khist[1][i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        if (wren) model_store(addr, st_data, bmask);
        m_edge = m_edge | rise;
        m_khist[1] = m_khist[0];
        m_khist[0] = ~key;
        m_swhist[1] = m_swhist[0];
        m_swhist[0] = sw;
        if (rden) m_ld_data = ld;
        m_ld_valid = rden;
        m_irq = irq_n;
        @(posedge clk);
        #1;
        for (int d = 0; d < 8; d++) exp_hex[7*d +: 7] = m_hex[d];
        check("ld_valid", ld_valid, m_ld_valid);
        if (m_ld_valid) check("ld_data", ld_data, m_ld_data);
        check("ledr", ledr, m_ledr);
        check("ledg", ledg, m_ledg);
        check("hex", hex, exp_hex);
        check("lcd", lcd, m_lcd);
        check("irq", irq, m_irq);
        check("hex4", hex4, exp_hex[27:0]);
    endtask

    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] bm,
                       input logic we, input logic re);
        addr = a; st_data = d; bmask = bm; wren = we; rden = re;
        tick();
        wren = 0; rden = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Asserts reset between edges, checks outputs clear at once, releases two edges later.
    task automatic do_reset();
        #3;
        rst = 1'b1;
        #1;
        check("rst_ledr", ledr, 0);
        check("rst_ledg", ledg, 0);
        check("rst_hex", hex, 0);
        check("rst_lcd", lcd, 0);
        check("rst_irq", irq, 0);
        check("rst_valid", ld_valid, 0);
        check("rst_ld_data", ld_data, 0);
        model_reset();
        wren = 0; rden = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    localparam logic [31:0] ALedr  = Base + 32'h0;
    localparam logic [31:0] ALedg  = Base + 32'h1000;
    localparam logic [31:0] AHex03 = Base + 32'h2000;
    localparam logic [31:0] AHex47 = Base + 32'h3000;
    localparam logic [31:0] ALcd   = Base + 32'h4000;
    localparam logic [31:0] AKey   = Base + 32'h5000;
    localparam logic [31:0] AKedge = Base + 32'h5004;
    localparam logic [31:0] AKmask = Base + 32'h5008;
    localparam logic [31:0] ASw    = Base + 32'h1_0000;
    localparam logic [31:0] AUnmap = Base + 32'h6000;

    logic [31:0] addr_tbl [14];

    initial begin
        rst = 1'b1; addr = 0; st_data = 0; bmask = 0; wren = 0; rden = 0;
        sw = 0; key = 4'hF;
        addr_tbl = '{ALedr, ALedg, AHex03, AHex47, ALcd, AKey, AKedge, AKmask, ASw,
                     AUnmap, Base + 32'h5010, Base - 32'h4, 32'h2000_0000, Base + 32'h2_0000};
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Reset mid-run with a load pending and key1 held through reset.
        bus(ALedr, 32'h0001_FFFF, 4'hF, 1, 0);
        key = 4'b1101;
        idle(3);
        addr = ALedr; rden = 1;
        do_reset();
        bus(ALedr, 0, 0, 0, 1);
        check("t1_ledr", ld_data, 32'h0);
        check("t1_valid", ld_valid, 1);
        idle(5);
        bus(AKedge, 0, 0, 0, 1);
        check("t1_held_edge", ld_data, 32'h2);
        key = 4'hF;
        idle(8);
        bus(AKedge, 32'hF, 4'b0001, 1, 0);

        // Byte enables and HEX lanes.
        bus(ALedr, 32'hA5A5_A5A5, 4'b0011, 1, 0);
        bus(ALedr, 0, 0, 0, 1);
        check("t2_ledr", ld_data, 32'h0000_A5A5);
        bus(AHex03, 32'h4F5B_3F3F, 4'hF, 1, 0);
        bus(AHex03, 32'h0000_7F06, 4'b0011, 1, 0);
        check("t2_hex_out", hex[27:0], {7'h4F, 7'h5B, 7'h7F, 7'h06});
        bus(AHex03, 0, 0, 0, 1);
        check("t2_hex_rd", ld_data, 32'h4F5B_7F06);
        bus(AHex03, 32'hFFFF_FFFF, 4'hF, 1, 0);
        bus(AHex03, 0, 0, 0, 1);
        check("t2_hex_bit7", ld_data, 32'h7F7F_7F7F);

        // Read-during-write returns old value; valid is a single-cycle pulse.
        bus(ALcd, 32'h1111_1111, 4'hF, 1, 0);
        bus(ALcd, 32'h1234_5678, 4'hF, 1, 1);
        check("t3_old", ld_data, 32'h1111_1111);
        check("t3_valid", ld_valid, 1);
        idle(1);
        check("t3_valid_pulse", ld_valid, 0);
        bus(ALcd, 0, 0, 0, 1);
        check("t3_new", ld_data, 32'h1234_5678);

        // Debounce: a 2-cycle glitch is filtered, a sustained press is accepted.
        bus(AKmask, 32'h1, 4'b0001, 1, 0);
        key = 4'b1110;
        idle(2);
        key = 4'hF;
        idle(6);
        bus(AKey, 0, 0, 0, 1);
        check("t4_glitch_key", ld_data, 32'h0);
        bus(AKedge, 0, 0, 0, 1);
        check("t4_glitch_edge", ld_data, 32'h0);
        key = 4'b1110;
        idle(5);
        bus(AKey, 0, 0, 0, 1);
        check("t4_key_early", ld_data, 32'h0);
        bus(AKey, 0, 0, 0, 1);
        check("t4_key", ld_data, 32'h1);
        bus(AKedge, 0, 0, 0, 1);
        check("t4_edge", ld_data, 32'h1);
        check("t4_irq", irq, 1);

        // W1C racing a fresh edge: the set wins.
        key = 4'hF;
        idle(8);
        bus(AKedge, 32'h1, 4'b0001, 1, 0);
        idle(1);
        check("t5_irq_cleared", irq, 0);
        key = 4'b1110;
        idle(5);
        bus(AKedge, 32'h1, 4'b0001, 1, 0);
        bus(AKedge, 0, 0, 0, 1);
        check("t5_race", ld_data, 32'h1);
        bus(AKedge, 32'h1, 4'b0001, 1, 0);
        check("t5_irq_lag", irq, 1);
        idle(1);
        check("t5_irq_clr", irq, 0);
        key = 4'hF;
        idle(8);

        // Unmapped window and HEX47 on a 4-digit build.
        addr = AUnmap; st_data = 32'hDEAD_BEEF; bmask = 4'hF; wren = 1;
        #1;
        check("t6_hit_unmapped", hit, 0);
        tick();
        wren = 0;
        bus(AUnmap, 0, 0, 0, 1);
        check("t6_unmapped_rd", ld_data, 32'h0);
        check("t6_unmapped_valid", ld_valid, 1);
        addr = AHex47; st_data = 32'h0102_0304; bmask = 4'hF; wren = 1;
        #1;
        check("t6_hit47_8", hit, 1);
        check("t6_hit47_4", hit4, 0);
        tick();
        wren = 0;
        bus(AHex47, 0, 0, 0, 1);
        check("t6_hex47_8", ld_data, 32'h0102_0304);
        check("t6_hex47_4", ld_data4, 32'h0);
        check("t6_valid_4", ld_valid4, 1);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            addr = addr_tbl[$urandom_range(13)] | 32'($urandom_range(3));
            st_data = $urandom;
            bmask = 4'($urandom);
            wren = ($urandom_range(2) == 0);
            rden = ($urandom_range(2) == 0);
            if ($urandom_range(15) == 0) sw = 18'($urandom);
            for (int i = 0; i < 4; i++) if ($urandom_range(9) == 0) key[i] = ~key[i];
            if (n == 300) begin
                rden = 1;
                do_reset();
            end else begin
                tick();
            end
        end
        wren = 0; rden = 0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
